writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Writer side of the CPU register file write port. It drives select, data_in and write_enable.
- Merges results from the ALU (single-cycle, no backpressure) and the load/store unit (valid/ready) into one registered write per cycle.
- A small load buffer absorbs collisions. Writes to x0 are discarded.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- LD_DEPTH, 2, load-result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  REG_AW  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  buffer can accept; equals not full
- lsu_rd  in  REG_AW  load destination register
- lsu_data  in  XLEN  load data
- rf_we  out  1  to register file write_enable
- rf_select  out  REG_AW  to register file select
- rf_data  out  XLEN  to register file data_in
- ld_pending  out  1  buffer non-empty or a load write is in the output register
- ld_count  out  clog2(LD_DEPTH)+1  buffer occupancy

Behaviour:
- Reset (async assert, sync release): rf_we=0, rf_select=0, rf_data=0, buffer empty, ld_count=0, lsu_ready=1, ld_pending=0.
- Load accept: on a clk edge with lsu_valid & lsu_ready. Loads with lsu_rd==0 are accepted and dropped; they do not enter the buffer.
- Source selection each cycle, in priority order:
  1. alu_valid & alu_rd!=0: ALU result.
  2. Buffer non-empty: buffer head, which is popped.
  3. Accepted load with rd!=0 and empty buffer: load result directly, bypassing the buffer, with no extra cycle.
  4. Otherwise no write.
- Accepted loads not consumed by rule 3 are pushed to the buffer tail.
- Output register: the selected source is registered on the edge. rf_we/rf_select/rf_data are valid the cycle after selection (latency 1); the register file commits on the following edge.
- rf_we=0 cycles hold the last rf_select/rf_data values.
- ALU results are never stalled or dropped except for rd==0.
- WAW ordering: an ALU result is younger than any buffered or same-cycle load.
  - A buffered entry whose rd equals a written alu_rd is invalidated. It is popped without a write when it reaches the head, and ld_count still counts it until it is popped.
  - A same-cycle load with lsu_rd==alu_rd is accepted and dropped.
- Full buffer: lsu_ready=0 combinationally from occupancy. A pop and a push in the same cycle while full is not allowed; ready reflects the start-of-cycle state.
- Pointers wrap modulo LD_DEPTH. An occupancy counter disambiguates full from empty.
- Reset mid-operation flushes the buffer and any pending write; buffered loads are lost.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds ports:
  - fwd_rs1, fwd_rs2  in  REG_AW
  - fwd_rs1_hit, fwd_rs2_hit  out  1
  - fwd_rs1_data, fwd_rs2_data  out  XLEN
- Behaviour with the macro: combinational match against the output register. hit = rf_we & rf_select==fwd_rsX & fwd_rsX!=0, and data=rf_data. This covers the cycle in which the asynchronous register file read still returns the old value.
- Without the macro: the ports are absent and no compare logic is built.

Decomposition:
- Package wb_pkg holds:
  - XLEN_DEF and REG_AW_DEF constants.
  - Constant REG_X0 = 0.
  - Typedef wb_entry_t {valid, rd, data}.
  - Typedef wb_src_e {SRC_NONE, SRC_ALU, SRC_BUF, SRC_LSU}.
- Sub-module wb_load_fifo: a circular buffer with push, pop, invalidate-by-rd, head, count and full outputs.
- The top level holds the selection logic, the output register and the optional forwarding.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_select=5, rf_data=0xDEADBEEF. Then rd=0 -> rf_we=0.
- Collision: ALU rd=3 and load rd=7 data=0x11 in the same cycle -> rf writes x3 next cycle, then x7=0x11 the cycle after; ld_count goes 1->0.
- Backpressure: ALU busy for 4 cycles while 3 loads are offered -> lsu_ready=0 after 2 accepted. The third load is accepted once the ALU idles. Loads write in order x10, x11, x12.
- WAW: buffered load rd=9, then ALU rd=9 data=0x5 -> single rf write x9=0x5; the buffered entry pops without a write.
- Async reset: assert rst_n=0 mid-burst with 2 loads buffered -> outputs 0 immediately, ld_count=0, lsu_ready=1, and no writes after release.
- WB_FWD_EN: ALU writes x4=0x22 and fwd_rs1=4 in the write cycle -> fwd_rs1_hit=1 and fwd_rs1_data=0x22. fwd_rs1=0 -> hit=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int REG_X0     = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_LSU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-result buffer with per-entry invalidate-by-rd for WAW ordering.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 2,
    parameter int PW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              inv_en,
    input  logic [REG_AW-1:0] inv_rd,
    output logic              head_valid,
    output logic [REG_AW-1:0] head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] inv_hit;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Stale slots may also match; harmless since a push rewrites valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_inv
            assign inv_hit[gi] = inv_en && (rd_mem[gi] == inv_rd);
        end
    endgenerate

    always_comb begin
        valid_d  = valid_q & ~inv_hit;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = valid_q[rd_ptr_q];
    assign head_rd    = rd_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into one registered register-file write per cycle.
// Optional macro WB_FWD_EN adds forwarding compares against the output register.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LD_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [REG_AW-1:0]         alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [REG_AW-1:0]         lsu_rd,
    input  logic [XLEN-1:0]           lsu_data,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_select,
    output logic [XLEN-1:0]           rf_data,
    output logic                      ld_pending,
`ifdef WB_FWD_EN
    input  logic [REG_AW-1:0]         fwd_rs1,
    input  logic [REG_AW-1:0]         fwd_rs2,
    output logic                      fwd_rs1_hit,
    output logic                      fwd_rs2_hit,
    output logic [XLEN-1:0]           fwd_rs1_data,
    output logic [XLEN-1:0]           fwd_rs2_data,
`endif
    output logic [$clog2(LD_DEPTH):0] ld_count
);

    localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

    logic              alu_wr, lsu_acc, lsu_live;
    logic              push, pop;
    wb_src_e           sel;
    logic              head_valid, fifo_full, fifo_empty;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_select_q, rf_select_d;
    logic [XLEN-1:0]   rf_data_q, rf_data_d;
    logic              ld_out_q, ld_out_d;

    wb_load_fifo #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (LD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_rd    (lsu_rd),
        .push_data  (lsu_data),
        .pop        (pop),
        .inv_en     (alu_wr),
        .inv_rd     (alu_rd),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (ld_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign lsu_ready = ~fifo_full;
    assign alu_wr    = alu_valid && (alu_rd != X0);
    assign lsu_acc   = lsu_valid && lsu_ready;
    // A same-cycle ALU write to the same rd is younger, so the load is dead.
    assign lsu_live  = lsu_acc && (lsu_rd != X0) && !(alu_wr && (lsu_rd == alu_rd));

    always_comb begin
        sel         = SRC_NONE;
        pop         = 1'b0;
        rf_we_d     = 1'b0;
        rf_select_d = rf_select_q;
        rf_data_d   = rf_data_q;
        ld_out_d    = 1'b0;
        if (alu_wr) begin
            sel         = SRC_ALU;
            rf_we_d     = 1'b1;
            rf_select_d = alu_rd;
            rf_data_d   = alu_data;
        end else if (!fifo_empty) begin
            sel = SRC_BUF;
            pop = 1'b1;
            if (head_valid) begin
                rf_we_d     = 1'b1;
                rf_select_d = head_rd;
                rf_data_d   = head_data;
                ld_out_d    = 1'b1;
            end
        end else if (lsu_live) begin
            sel         = SRC_LSU;
            rf_we_d     = 1'b1;
            rf_select_d = lsu_rd;
            rf_data_d   = lsu_data;
            ld_out_d    = 1'b1;
        end
        push = lsu_live && (sel != SRC_LSU);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q     <= 1'b0;
            rf_select_q <= '0;
            rf_data_q   <= '0;
            ld_out_q    <= 1'b0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_select_q <= rf_select_d;
            rf_data_q   <= rf_data_d;
            ld_out_q    <= ld_out_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_select  = rf_select_q;
    assign rf_data    = rf_data_q;
    assign ld_pending = (ld_count != '0) || ld_out_q;

`ifdef WB_FWD_EN
    // Covers the cycle where the asynchronous register-file read is still stale.
    assign fwd_rs1_hit  = rf_we_q && (rf_select_q == fwd_rs1) && (fwd_rs1 != X0);
    assign fwd_rs2_hit  = rf_we_q && (rf_select_q == fwd_rs2) && (fwd_rs2 != X0);
    assign fwd_rs1_data = rf_data_q;
    assign fwd_rs2_data = rf_data_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (default LD_DEPTH=2).
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_select;
    logic [31:0] rf_data;
    logic        ld_pending;
    logic [1:0]  ld_count;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_we      (rf_we),
        .rf_select  (rf_select),
        .rf_data    (rf_data),
        .ld_pending (ld_pending),
`ifdef WB_FWD_EN
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data),
`endif
        .ld_count   (ld_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] sel, input logic [31:0] data);
        check({tag, ".we"},   32'(rf_we),     32'(we));
        check({tag, ".sel"},  32'(rf_select), 32'(sel));
        check({tag, ".data"}, rf_data,        data);
    endtask

    task automatic chk_ld(input string tag, input logic [1:0] cnt, input logic pend);
        check({tag, ".cnt"},  32'(ld_count),   32'(cnt));
        check({tag, ".pend"}, 32'(ld_pending), 32'(pend));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
`ifdef WB_FWD_EN
        fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
`endif
        #2;
        chk_rf("reset", 1'b0, 5'd0, 32'd0);
        chk_ld("reset", 2'd0, 1'b0);
        check("reset.rdy", 32'(lsu_ready), 32'd1);
        step(); step();
        rst_n = 1'b1;
        step();

        // ALU only, then rd=0 is discarded and outputs hold
        alu(5'd5, 32'hDEADBEEF);
        step();
        chk_rf("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        check("alu5.pend", 32'(ld_pending), 32'd0);
        alu(5'd0, 32'h1234);
        step();
        chk_rf("alu0", 1'b0, 5'd5, 32'hDEADBEEF);

        // Collision: ALU wins, load buffered then written
        idle();
        alu(5'd3, 32'hAA);
        lsu(5'd7, 32'h11);
        check("col.rdy", 32'(lsu_ready), 32'd1);
        step();
        chk_rf("col.x3", 1'b1, 5'd3, 32'hAA);
        chk_ld("col.x3", 2'd1, 1'b1);
        idle();
        step();
        chk_rf("col.x7", 1'b1, 5'd7, 32'h11);
        chk_ld("col.x7", 2'd0, 1'b1);
        step();
        check("col.idle.we", 32'(rf_we), 32'd0);
        chk_ld("col.idle", 2'd0, 1'b0);

        // Bypass: lone load writes with no extra cycle
        lsu(5'd8, 32'h88);
        step();
        chk_rf("byp.x8", 1'b1, 5'd8, 32'h88);
        chk_ld("byp.x8", 2'd0, 1'b1);
        idle();
        step();

        // Backpressure: ALU busy 4 cycles, 3 loads offered
        alu(5'd20, 32'h120); lsu(5'd10, 32'hAA);
        step();
        chk_rf("bp.c0", 1'b1, 5'd20, 32'h120);
        alu(5'd21, 32'h121); lsu(5'd11, 32'hAB);
        step();
        chk_rf("bp.c1", 1'b1, 5'd21, 32'h121);
        check("bp.c1.cnt", 32'(ld_count), 32'd2);
        alu(5'd22, 32'h122); lsu(5'd12, 32'hAC);
        check("bp.c2.rdy", 32'(lsu_ready), 32'd0);
        step();
        chk_rf("bp.c2", 1'b1, 5'd22, 32'h122);
        alu(5'd23, 32'h123);
        step();
        chk_rf("bp.c3", 1'b1, 5'd23, 32'h123);
        check("bp.c3.cnt", 32'(ld_count), 32'd2);
        alu_valid = 1'b0; alu_rd = 5'd0;
        check("bp.c4.rdy", 32'(lsu_ready), 32'd0);
        step();
        chk_rf("bp.x10", 1'b1, 5'd10, 32'hAA);
        check("bp.x10.cnt", 32'(ld_count), 32'd1);
        check("bp.c5.rdy", 32'(lsu_ready), 32'd1);
        step();
        chk_rf("bp.x11", 1'b1, 5'd11, 32'hAB);
        check("bp.x11.cnt", 32'(ld_count), 32'd1);
        idle();
        step();
        chk_rf("bp.x12", 1'b1, 5'd12, 32'hAC);
        chk_ld("bp.x12", 2'd0, 1'b1);
        step();

        // WAW: buffered x9 killed by younger ALU write
        alu(5'd1, 32'h1); lsu(5'd9, 32'h99);
        step();
        chk_rf("waw.x1", 1'b1, 5'd1, 32'h1);
        idle();
        alu(5'd9, 32'h5);
        step();
        chk_rf("waw.x9", 1'b1, 5'd9, 32'h5);
        check("waw.x9.cnt", 32'(ld_count), 32'd1);
        idle();
        step();
        chk_rf("waw.pop", 1'b0, 5'd9, 32'h5);
        chk_ld("waw.pop", 2'd0, 1'b0);

        // Same-cycle load to same rd is dropped
        alu(5'd6, 32'h66); lsu(5'd6, 32'h77);
        step();
        chk_rf("same.x6", 1'b1, 5'd6, 32'h66);
        check("same.cnt", 32'(ld_count), 32'd0);
        idle();
        step();
        check("same.after.we", 32'(rf_we), 32'd0);

        // Load to x0 is accepted and dropped
        lsu(5'd0, 32'h55);
        step();
        check("ldx0.we", 32'(rf_we), 32'd0);
        check("ldx0.cnt", 32'(ld_count), 32'd0);
        idle();

        // Async reset mid-burst with two loads buffered
        alu(5'd2, 32'h2); lsu(5'd13, 32'hD);
        step();
        lsu(5'd14, 32'hE);
        step();
        check("rst.pre.cnt", 32'(ld_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rf("rst.async", 1'b0, 5'd0, 32'd0);
        chk_ld("rst.async", 2'd0, 1'b0);
        check("rst.async.rdy", 32'(lsu_ready), 32'd1);
        idle();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst.post.we", 32'(rf_we), 32'd0);
            check("rst.post.cnt", 32'(ld_count), 32'd0);
        end

`ifdef WB_FWD_EN
        alu(5'd4, 32'h22);
        step();
        idle();
        fwd_rs1 = 5'd4; fwd_rs2 = 5'd5;
        #1;
        check("fwd.hit1", 32'(fwd_rs1_hit), 32'd1);
        check("fwd.data1", fwd_rs1_data, 32'h22);
        check("fwd.hit2", 32'(fwd_rs2_hit), 32'd0);
        fwd_rs1 = 5'd0;
        #1;
        check("fwd.x0", 32'(fwd_rs1_hit), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
